// File: rtl/mem_access_seq.sv
// LC-3 memory access sequencer: turns control-unit strobes into timed async SRAM cycles with WAIT_CYCLES wait states.
// Optional MEM_SEQ_MMIO_EN maps address 16'hFFFF to Switches (read) and Hex_Out (write). Pin outputs trail the state register by one cycle.
module mem_access_seq #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Mem_CE,
  input  logic              Mem_OE,
  input  logic              Mem_WE,
  input  logic [15:0]       MAR,
  input  logic [15:0]       MDR_out,
  output logic [15:0]       Data_to_CPU,
  output logic              Mem_Ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [15:0]       SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  input  logic [15:0]       SRAM_DQ_in
`ifdef MEM_SEQ_MMIO_EN
  ,
  input  logic [15:0]       Switches,
  output logic [15:0]       Hex_Out
`endif
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_WAIT, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t     state, next_state;
  logic [2:0] wait_cnt;
  logic       wr_req, rd_req, io_hit, io_sel;

  assign wr_req = !Mem_CE && !Mem_WE;
  assign rd_req = !Mem_CE && !Mem_OE;

`ifdef MEM_SEQ_MMIO_EN
  assign io_hit = (MAR == 16'hFFFF);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      io_sel  <= 1'b0;
      Hex_Out <= 16'h0000;
    end else begin
      if (state == IDLE) io_sel <= io_hit && (wr_req || rd_req);
      if (state == WR_HOLD && io_sel) Hex_Out <= SRAM_DQ_out;
    end
  end
`else
  assign io_hit = 1'b0;
  assign io_sel = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // I/O accesses skip the setup state and enter the countdown with zero wait.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wr_req)      next_state = io_hit ? WR_PULSE : WR_SETUP;
        else if (rd_req) next_state = io_hit ? RD_WAIT  : RD_SETUP;
      end
      RD_SETUP: next_state = RD_WAIT;
      RD_WAIT:  if (wait_cnt == 3'd0) next_state = RD_LATCH;
      RD_LATCH: next_state = DONE;
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: if (wait_cnt == 3'd0) next_state = WR_HOLD;
      WR_HOLD:  next_state = DONE;
      DONE:     if (Mem_OE && Mem_WE) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE:               wait_cnt <= 3'd0;
        RD_SETUP, WR_SETUP: wait_cnt <= WAIT_INIT;
        RD_WAIT, WR_PULSE:  if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        default:            wait_cnt <= wait_cnt;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= 16'h0000;
      Data_to_CPU <= 16'h0000;
    end else begin
      if (state == IDLE && (wr_req || rd_req)) SRAM_ADDR <= ADDR_W'(MAR);
      if (state == IDLE && wr_req) SRAM_DQ_out <= MDR_out;
      if (state == RD_LATCH) begin
`ifdef MEM_SEQ_MMIO_EN
        Data_to_CPU <= io_sel ? Switches : SRAM_DQ_in;
`else
        Data_to_CPU <= SRAM_DQ_in;
`endif
      end
    end
  end

  // Reset forces every strobe inactive at once, aborting any access in flight.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_DQ_oe <= 1'b0;
      Mem_Ready  <= 1'b0;
    end else begin
      SRAM_CE_N  <= !(!io_sel && (state inside {RD_SETUP, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD}));
      SRAM_OE_N  <= !(!io_sel && (state inside {RD_SETUP, RD_WAIT}));
      SRAM_WE_N  <= !(!io_sel && (state == WR_PULSE));
      SRAM_DQ_oe <= !io_sel && (state inside {WR_SETUP, WR_PULSE, WR_HOLD});
      Mem_Ready  <= (state == RD_LATCH) || (state == WR_HOLD);
    end
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Memory access sequencer between the LC-3 control unit and the external async SRAM.
- Turns the control unit's active-low level strobes (Mem_CE, Mem_OE, Mem_WE) plus MAR/MDR into correctly timed SRAM read and write cycles, with a programmable number of wait states.
- Returns read data to the MDR input mux and raises Mem_Ready so the control FSM can sequence its memory states against real SRAM latency.

Parameters:
- WAIT_CYCLES, 1, SRAM access wait states inserted per read/write; legal range 0..7.
- ADDR_W, 20, SRAM address width; upper bits above the 16-bit MAR are zero-filled.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Mem_CE  in  1  active-low chip enable from control unit.
- Mem_OE  in  1  active-low read request from control unit.
- Mem_WE  in  1  active-low write request from control unit.
- MAR  in  16  word address.
- MDR_out  in  16  write data.
- Data_to_CPU  out  16  read data, registered.
- Mem_Ready  out  1  one-cycle pulse when the access completes.
- SRAM_ADDR  out  ADDR_W  SRAM address, registered.
- SRAM_CE_N  out  1  SRAM chip enable, active-low, registered.
- SRAM_OE_N  out  1  SRAM output enable, active-low, registered.
- SRAM_WE_N  out  1  SRAM write enable, active-low, registered.
- SRAM_DQ_out  out  16  write data to pad driver.
- SRAM_DQ_oe  out  1  pad driver enable, high = drive.
- SRAM_DQ_in  in  16  data from pads.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - State is IDLE.
  - SRAM_CE_N, SRAM_OE_N and SRAM_WE_N are all 1.
  - SRAM_DQ_oe = 0; Mem_Ready = 0; Data_to_CPU = 0; SRAM_ADDR = 0; SRAM_DQ_out = 0; wait counter = 0.
- Reset asserted mid-access: the cycle is aborted immediately. SRAM_WE_N goes high at once, so no partial write pulse is stretched.
- FSM states: IDLE, RD_SETUP, RD_WAIT, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - With Mem_CE=0 and Mem_WE=0: latch MAR and MDR_out, go to WR_SETUP.
  - Else with Mem_CE=0 and Mem_OE=0: latch MAR, go to RD_SETUP.
  - Write wins if both strobes are low. Mem_CE=1 means no request.
- Read path:
  - RD_SETUP: CE_N=0, OE_N=0, load counter with WAIT_CYCLES.
  - RD_WAIT: decrement the counter; stay while it is nonzero. With WAIT_CYCLES=0, go straight to RD_LATCH.
  - RD_LATCH: Data_to_CPU <= SRAM_DQ_in; pulse Mem_Ready; go to DONE.
  - Read latency from strobe sampled to Mem_Ready = WAIT_CYCLES+3 cycles.
  - Data_to_CPU is valid from the cycle Mem_Ready is high and holds until the next read latches.
- Write path:
  - WR_SETUP: CE_N=0, DQ_oe=1, address and data stable, WE_N=1.
  - WR_PULSE: WE_N=0 for WAIT_CYCLES+1 cycles.
  - WR_HOLD: WE_N=1, DQ_oe stays 1 for one cycle; pulse Mem_Ready; go to DONE.
  - SRAM_DQ_oe is never 1 while SRAM_OE_N is 0.
- DONE:
  - All SRAM strobes high, DQ_oe=0.
  - Return to IDLE only once Mem_OE and Mem_WE are both 1. A held strobe therefore causes exactly one access.
- Address mapping: SRAM_ADDR = {zeros, MAR}, captured at request; later MAR changes are ignored until DONE.
- Mem_Ready is high for exactly one cycle per access, never in IDLE or DONE.

Optional Feature:
- Macro: MEM_SEQ_MMIO_EN.
- When defined:
  - Address 16'hFFFF is I/O, not SRAM. New ports are Switches (in, 16) and Hex_Out (out, 16, reset 0).
  - Read of FFFF: no SRAM strobes; Data_to_CPU <= Switches; Mem_Ready pulses 2 cycles after the request is sampled.
  - Write of FFFF: Hex_Out <= MDR_out; no SRAM strobes; Mem_Ready pulses 2 cycles after the request is sampled.
  - Both I/O paths go through DONE as normal.
- When undefined: FFFF is an ordinary SRAM address; the extra ports are absent.

Test Plan:
- Read, WAIT_CYCLES=1: MAR=16'h0040, SRAM model returns 16'h1234, Mem_CE=0/Mem_OE=0 held -> Mem_Ready one pulse 4 cycles after sampling; Data_to_CPU=16'h1234; OE_N low 3 cycles; DQ_oe stays 0.
- Write, WAIT_CYCLES=1: MAR=16'h0041, MDR_out=16'hBEEF -> WE_N low exactly 2 cycles bracketed by WE_N high with DQ_oe=1; SRAM model at 0x00041 holds 16'hBEEF; single Mem_Ready pulse.
- Held strobe: keep Mem_OE=0 for 20 cycles -> exactly one SRAM read and one Mem_Ready pulse; sequencer sits in DONE until Mem_OE=1.
- Simultaneous Mem_OE=0 and Mem_WE=0 -> write cycle performed, OE_N stays 1 throughout.
- Reset_n driven low during WR_PULSE -> WE_N, CE_N and OE_N go to 1 the same cycle without a clock edge; DQ_oe=0; after release a new read completes normally.
- With MEM_SEQ_MMIO_EN defined: write 16'h00A5 to FFFF -> Hex_Out=16'h00A5, SRAM strobes never low. Read FFFF with Switches=16'h0F0F -> Data_to_CPU=16'h0F0F.
